// File: rtl/seg_letter_decoder.sv
// Debounced 7-segment letter decoder: locks onto A/N/B/D after STABLE_CYCLES identical samples.
// Optional macro SEG_DP_CHECK_EN makes a lit decimal point (seg_in[7]) unrecognized.
module seg_letter_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [7:0]       seg_in,
    input  logic             sample_en,
    output logic [1:0]       code,
    output logic             code_valid,
    output logic             invalid,
    output logic [CNT_W-1:0] change_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       STABLE  = 4'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic [1:0] cand;
    logic [3:0] run;
    logic       lock_seen;

    logic       hit;
    logic [1:0] letter;
    logic       take;
    logic [3:0] new_run;
    logic       lock_now;

    always_comb begin
        hit    = 1'b1;
        letter = 2'b00;
        case (seg_in[6:0])
            7'h77:   letter = 2'b00;
            7'h37:   letter = 2'b01;
            7'h7C:   letter = 2'b10;
            7'h5E:   letter = 2'b11;
            default: hit = 1'b0;
        endcase
`ifdef SEG_DP_CHECK_EN
        if (seg_in[7]) hit = 1'b0;
`endif
    end

    // A recognized sample either extends the current run or starts a fresh one;
    // the held code in LOCKED is the only case that changes nothing.
    always_comb begin
        take     = hit && !(state == LOCKED && letter == code);
        new_run  = (state == QUALIFY && letter == cand) ? run + 4'd1 : 4'd1;
        lock_now = take && (new_run >= STABLE);
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cand       <= 2'b00;
            run        <= 4'd0;
            lock_seen  <= 1'b0;
            code       <= 2'b00;
            code_valid <= 1'b0;
            invalid    <= 1'b0;
            change_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            invalid <= 1'b0;
            if (sample_en) begin
                if (!hit) begin
                    state      <= IDLE;
                    run        <= 4'd0;
                    code_valid <= 1'b0;
                    invalid    <= 1'b1;
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                end else if (take) begin
                    cand <= letter;
                    run  <= new_run;
                    if (lock_now) begin
                        state      <= LOCKED;
                        code       <= letter;
                        code_valid <= 1'b1;
                        lock_seen  <= 1'b1;
                        if (lock_seen && letter != code && change_cnt != CNT_MAX)
                            change_cnt <= change_cnt + 1'b1;
                    end else begin
                        state <= QUALIFY;
                    end
                end
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_seg_letter_decoder.sv
// Directed bench for seg_letter_decoder (STABLE_CYCLES=4, CNT_W=8); fsm_state 0=IDLE 1=QUALIFY 2=LOCKED.
module tb_seg_letter_decoder;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic       sample_en = 1'b0;
    logic [1:0] code;
    logic       code_valid;
    logic       invalid;
    logic [7:0] change_cnt;
    logic [7:0] err_cnt;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;

    seg_letter_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk_2(clk_2), .reset(reset), .seg_in(seg_in), .sample_en(sample_en),
        .code(code), .code_valid(code_valid), .invalid(invalid),
        .change_cnt(change_cnt), .err_cnt(err_cnt), .fsm_state(fsm_state)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_code, input logic e_valid,
                           input logic e_inv, input logic [7:0] e_chg, input logic [7:0] e_err);
        chk({tag, ".code"}, 32'(code), 32'(e_code));
        chk({tag, ".valid"}, 32'(code_valid), 32'(e_valid));
        chk({tag, ".invalid"}, 32'(invalid), 32'(e_inv));
        chk({tag, ".change_cnt"}, 32'(change_cnt), 32'(e_chg));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_err));
    endtask

    // One sampling edge with the given pattern; returns 1 time unit after it.
    task automatic sample(input logic [7:0] v);
        @(negedge clk_2);
        seg_in    = v;
        sample_en = 1'b1;
        @(posedge clk_2);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic idle(input int n, input logic [7:0] v);
        @(negedge clk_2);
        seg_in    = v;
        sample_en = 1'b0;
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk_all("reset", 2'b00, 1'b0, 1'b0, 8'd0, 8'd0);
        chk("reset.state", 32'(fsm_state), 32'd0);
        @(negedge clk_2);
        reset = 1'b0;

        // Lock A after four samples
        repeat (3) sample(8'h77);
        chk("a3.valid", 32'(code_valid), 32'd0);
        chk("a3.state", 32'(fsm_state), 32'd1);
        sample(8'h77);
        chk_all("lock_a", 2'b00, 1'b1, 1'b0, 8'd0, 8'd0);
        chk("lock_a.state", 32'(fsm_state), 32'd2);

        // A held while D qualifies, interrupted by one A, then D locks
        repeat (3) sample(8'h5E);
        chk_all("d3", 2'b00, 1'b1, 1'b0, 8'd0, 8'd0);
        chk("d3.state", 32'(fsm_state), 32'd1);
        idle(3, 8'h00);
        chk_all("hold_en0", 2'b00, 1'b1, 1'b0, 8'd0, 8'd0);
        chk("hold_en0.state", 32'(fsm_state), 32'd1);
        sample(8'h77);
        chk_all("interrupt_a", 2'b00, 1'b1, 1'b0, 8'd0, 8'd0);
        repeat (3) sample(8'h5E);
        chk_all("d_run3", 2'b00, 1'b1, 1'b0, 8'd0, 8'd0);
        sample(8'h5E);
        chk_all("lock_d", 2'b11, 1'b1, 1'b0, 8'd1, 8'd0);

        // Lock N, then one unrecognized sample
        repeat (4) sample(8'h37);
        chk_all("lock_n", 2'b01, 1'b1, 1'b0, 8'd2, 8'd0);
        sample(8'h00);
        chk_all("err_n", 2'b01, 1'b0, 1'b1, 8'd2, 8'd1);
        chk("err_n.state", 32'(fsm_state), 32'd0);
        idle(1, 8'h37);
        chk_all("pulse_end", 2'b01, 1'b0, 1'b0, 8'd2, 8'd1);

        // Back-to-back errors while idle
        sample(8'h00);
        chk_all("b2b_1", 2'b01, 1'b0, 1'b1, 8'd2, 8'd2);
        sample(8'h49);
        chk_all("b2b_2", 2'b01, 1'b0, 1'b1, 8'd2, 8'd3);

        // Relock the same letter: no change counted
        repeat (3) sample(8'h37);
        chk_all("relock_n3", 2'b01, 1'b0, 1'b0, 8'd2, 8'd3);
        sample(8'h37);
        chk_all("relock_n", 2'b01, 1'b1, 1'b0, 8'd2, 8'd3);

        // Decimal point set on an A pattern
`ifdef SEG_DP_CHECK_EN
        repeat (3) sample(8'hF7);
        chk_all("dp3", 2'b01, 1'b0, 1'b1, 8'd2, 8'd6);
        sample(8'hF7);
        chk_all("dp4", 2'b01, 1'b0, 1'b1, 8'd2, 8'd7);
`else
        repeat (3) sample(8'hF7);
        chk_all("dp3", 2'b01, 1'b1, 1'b0, 8'd2, 8'd3);
        sample(8'hF7);
        chk_all("dp4", 2'b00, 1'b1, 1'b0, 8'd3, 8'd3);
`endif

        // Reset in the middle of a B run
        repeat (2) sample(8'h7C);
        #2 reset = 1'b1;
        #1;
        chk_all("mid_reset", 2'b00, 1'b0, 1'b0, 8'd0, 8'd0);
        chk("mid_reset.state", 32'(fsm_state), 32'd0);
        @(negedge clk_2);
        reset = 1'b0;
        repeat (3) sample(8'h7C);
        chk_all("b3_after_reset", 2'b00, 1'b0, 1'b0, 8'd0, 8'd0);
        sample(8'h7C);
        chk_all("lock_b", 2'b10, 1'b1, 1'b0, 8'd0, 8'd0);

        // err_cnt saturation over 300 unrecognized samples
        repeat (255) sample(8'h12);
        chk_all("err255", 2'b10, 1'b0, 1'b1, 8'd0, 8'hFF);
        repeat (45) sample(8'h12);
        chk_all("err300", 2'b10, 1'b0, 1'b1, 8'd0, 8'hFF);

        // change_cnt saturation: every lock alternates A/N and differs from B before it
        for (int i = 0; i < 255; i++) repeat (4) sample((i % 2 == 0) ? 8'h77 : 8'h37);
        chk_all("chg255", 2'b00, 1'b1, 1'b0, 8'hFF, 8'hFF);
        for (int i = 255; i < 260; i++) repeat (4) sample((i % 2 == 0) ? 8'h77 : 8'h37);
        chk_all("chg260", 2'b01, 1'b1, 1'b0, 8'hFF, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
